// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial add/subtract sequencer. One full-adder cell and a carry flop are
// reused over WIDTH clock cycles, LSB first, to form a+b or a-b (a + ~b + 1).
// It is the small-area alternative to the ripple-carry ALU.
//
// Configuration macro:
//   SERIAL_ADDSUB_OVF_EN  defined   : overflow = carry_into_MSB ^ carry_out,
//                                     registered on entry to DONE and held
//                                     until the next accepted start.
//                         undefined : overflow is tied to 0 and its register
//                                     is not built.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   start      in   1      request, accepted only in IDLE
//   op         in   1      0 = add, 1 = subtract (sampled with start)
//   a, b       in   WIDTH  operands (sampled with start)
//   busy       out  1      high while not IDLE
//   done       out  1      one-cycle pulse, result/flags valid
//   result     out  WIDTH  sum/difference, held until next accepted start
//   carry_out  out  1      final carry (subtract: 1 = no borrow)
//   overflow   out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub_ctrl #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [WIDTH-1:0] result_r;
   logic [CW-1:0]    count_r;
   logic             cy_r;
   logic             busy_r;
   logic             done_r;
   logic             carry_out_r;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             overflow_r;
`endif

   logic             sum_s;
   logic             cy_next_s;

   // Full-adder sum bit.
   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   // Full-adder carry (majority of three).
   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   // The shared adder cell works on the current LSBs of both shift registers.
   always_comb begin
      sum_s     = fa_sum(sh_a_r[0], sh_b_r[0], cy_r);
      cy_next_s = fa_carry(sh_a_r[0], sh_b_r[0], cy_r);
   end

   // Sequencer: IDLE -> RUN (WIDTH steps) -> DONE -> IDLE, with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         sh_a_r      <= {WIDTH{1'b0}};
         sh_b_r      <= {WIDTH{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         count_r     <= {CW{1'b0}};
         cy_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         carry_out_r <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         overflow_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  sh_a_r      <= a;
                  // Subtraction is a + ~b with the carry seeded to 1.
                  sh_b_r      <= op ? ~b : b;
                  cy_r        <= op;
                  count_r     <= {CW{1'b0}};
                  result_r    <= {WIDTH{1'b0}};
                  carry_out_r <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
                  overflow_r  <= 1'b0;
`endif
                  busy_r      <= 1'b1;
                  state_r     <= ST_RUN;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sh_a_r   <= {1'b0, sh_a_r[WIDTH-1:1]};
               sh_b_r   <= {1'b0, sh_b_r[WIDTH-1:1]};
               cy_r     <= cy_next_s;
               // New sum bit enters at the MSB so the LSB ends up at bit 0.
               result_r <= {sum_s, result_r[WIDTH-1:1]};
               count_r  <= count_r + 1'b1;
               if (count_r == CW'(WIDTH - 1)) begin
                  carry_out_r <= cy_next_s;
`ifdef SERIAL_ADDSUB_OVF_EN
                  // cy_r here is the carry into the MSB position.
                  overflow_r  <= cy_r ^ cy_next_s;
`endif
                  done_r      <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  state_r     <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign carry_out = carry_out_r;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign overflow  = overflow_r;
`else
   assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//
// Scoreboard bench for serial_addsub_ctrl (WIDTH=5). The driver pushes the
// arithmetic expectation of every accepted operation into a queue; a monitor
// pops and compares whenever done is seen, also checking latency and the
// single-cycle done pulse.
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         cy;
      logic         ov;
      int           acc;
   } exp_t;

   exp_t         sb_q[$];
   logic         done_prev = 1'b0;
   logic [W-1:0] last_res  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic modulo 2^W and a signed range test.
   function automatic exp_t model(input logic o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input int acc);
      exp_t e;
      int ux, uy, full, sx, sy, sr;
      ux   = int'(x);
      uy   = int'(y);
      full = o ? ux + ((1 << W) - uy) : ux + uy;
      e.res = W'(full % (1 << W));
      e.cy  = 1'((full >> W) & 1);
      sx = x[W-1] ? ux - (1 << W) : ux;
      sy = y[W-1] ? uy - (1 << W) : uy;
      sr = o ? sx - sy : sx + sy;
`ifdef SERIAL_ADDSUB_OVF_EN
      e.ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
`else
      e.ov = 1'b0;
`endif
      e.acc = acc;
      return e;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (done === 1'b1) begin
            chk("done_single_cycle", 32'(done_prev), 32'd0);
            chk("busy_with_done", 32'(busy), 32'd1);
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("result", 32'(result), 32'(e.res));
               chk("carry_out", 32'(carry_out), 32'(e.cy));
               chk("overflow", 32'(overflow), 32'(e.ov));
               chk("latency", 32'(cyc - e.acc), 32'(W));
               last_res = e.res;
            end
         end
         done_prev = done;
      end else begin
         done_prev = 1'b0;
      end
   end

   // Issue one operation once the DUT is idle; optionally re-pulse start mid-run.
   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit repulse);
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(busy), 32'd0);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      sb_q.push_back(model(o, x, y, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      op = 1'($urandom_range(1, 0));
      a  = W'($urandom_range(31, 0));
      b  = W'($urandom_range(31, 0));
      if (repulse) begin
         @(negedge clk);
         start = 1'b1;
         op = 1'($urandom_range(1, 0));
         a  = W'($urandom_range(31, 0));
         b  = W'($urandom_range(31, 0));
         @(negedge clk);
         start = 1'b0;
         chk("busy_during_run", 32'(busy), 32'd1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases.
      issue(1'b0, 5'b01001, 5'b00101, 1'b0);
      issue(1'b1, 5'b00000, 5'b10010, 1'b0);
      issue(1'b0, 5'b11111, 5'b00001, 1'b0);
      issue(1'b0, 5'b01111, 5'b00001, 1'b0);
      issue(1'b1, 5'b10000, 5'b00001, 1'b0);
      issue(1'b0, 5'b00110, 5'b00111, 1'b1);
      issue(1'b1, 5'b00000, 5'b00000, 1'b0);
      drain();
      repeat (3) @(negedge clk);
      chk("result_hold", 32'(result), 32'(last_res));
      chk("done_idle", 32'(done), 32'd0);

      // Reset in the third RUN cycle aborts the operation without a done.
      op = 1'b0;
      a  = 5'b10101;
      b  = 5'b01010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_carry", 32'(carry_out), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      issue(1'b0, 5'b00011, 5'b00001, 1'b0);

      // Randomized operations, some with a mid-run start re-pulse.
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom_range(1, 0)), W'($urandom_range(31, 0)),
               W'($urandom_range(31, 0)), ($urandom_range(3, 0) == 0));
      end
      drain();
      repeat (3) @(negedge clk);
      chk("result_hold_end", 32'(result), 32'(last_res));
      chk("queue_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
